// File: rtl/floor_request_dispatcher_if.sv
// Call/dispatch bundle between the floor request dispatcher and its environment.
// master: the dispatcher. It consumes buttons, car position, completion and alerts,
//         and drives the target floor, lamp state, busy and timeout status.
// slave : the environment side (controller, alert system, button panel).
interface floor_request_dispatcher_if;
  logic [3:0] CALL_BUTTONS;     // level button inputs, bit i = floor i
  logic [3:0] CURRENT_FLOOR;    // one-hot car position
  logic       COMPLETE;         // controller arrival report
  logic       DOOR_ALERT;
  logic       WEIGHT_ALERT;
  logic [3:0] REQUESTED_FLOOR;  // one-hot target or 0
  logic [3:0] PENDING;          // latched calls
  logic       BUSY;
  logic       TIMEOUT_ERR;

  modport master (
    input  CALL_BUTTONS, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
    output REQUESTED_FLOOR, PENDING, BUSY, TIMEOUT_ERR
  );

  modport slave (
    output CALL_BUTTONS, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
    input  REQUESTED_FLOOR, PENDING, BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/floor_request_dispatcher.sv
// Floor request dispatcher: latches call-button rising edges into a pending-call
// register, picks the next target floor with a SCAN policy, holds it on
// REQUESTED_FLOOR until the controller reports COMPLETE at that floor, then
// enforces a door dwell before the next selection.
// Ports:
//   clk - system clock
//   rst - asynchronous active-low reset
//   bus - dispatcher side (master) of floor_request_dispatcher_if
module floor_request_dispatcher #(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic                        clk,
  input logic                        rst,
  floor_request_dispatcher_if.master bus
);

  localparam int unsigned CntMax = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES
                                                                  : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSelect, StDispatch, StDwell} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [3:0]      btn_sync;
  logic [3:0]      btn_hist;
  logic [3:0]      pending;
  logic [3:0]      req_floor;
  logic            busy;
  logic            timeout_err;
  logic            dir_up;

  logic [3:0] cur;
  logic       pos_valid;
  logic       alert;
  logic [3:0] rise;
  logic       served;
  logic       at_floor;
  logic [1:0] cur_idx;
  logic [3:0] up_tgt;
  logic [3:0] dn_tgt;
  logic [3:0] clr_mask;

  assign cur       = bus.CURRENT_FLOOR;
  assign pos_valid = (cur != 4'd0) && ((cur & (cur - 4'd1)) == 4'd0);
  assign alert     = bus.DOOR_ALERT | bus.WEIGHT_ALERT;
  assign rise      = btn_sync & ~btn_hist;
  assign served    = (state == StDispatch) && bus.COMPLETE && (cur == req_floor);
  assign at_floor  = (state == StSelect) && pos_valid && ((pending & cur) != 4'd0);
  // A clear of a pending bit overrides a same-cycle button edge on that bit.
  assign clr_mask  = served ? req_floor : (at_floor ? cur : 4'd0);

  // Nearest pending floor above (lowest index above) and below (highest index below).
  always_comb begin
    cur_idx = 2'd0;
    up_tgt  = 4'd0;
    dn_tgt  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (cur[i]) cur_idx = 2'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (pending[i] && (i > int'(cur_idx))) begin
        up_tgt    = 4'd0;
        up_tgt[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pending[i] && (i < int'(cur_idx))) begin
        dn_tgt    = 4'd0;
        dn_tgt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      cnt         <= '0;
      btn_sync    <= 4'b1111;  // held buttons look already-pressed, so no edge
      btn_hist    <= 4'b1111;
      pending     <= 4'd0;
      req_floor   <= 4'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      dir_up      <= 1'b1;
    end else begin
      btn_sync <= bus.CALL_BUTTONS;
      btn_hist <= btn_sync;
      pending  <= (pending | rise) & ~clr_mask;

      unique case (state)
        StIdle: begin
          if ((pending != 4'd0) && pos_valid && !alert) state <= StSelect;
        end
        StSelect: begin
          cnt <= '0;
          if (!pos_valid) begin
            state <= StIdle;
          end else if (at_floor) begin
            state <= StDwell;
            busy  <= 1'b1;
          end else if (dir_up && (up_tgt != 4'd0)) begin
            req_floor <= up_tgt;
            state     <= StDispatch;
            busy      <= 1'b1;
          end else if (!dir_up && (dn_tgt != 4'd0)) begin
            req_floor <= dn_tgt;
            state     <= StDispatch;
            busy      <= 1'b1;
          end else if (dir_up && (dn_tgt != 4'd0)) begin
            dir_up    <= 1'b0;
            req_floor <= dn_tgt;
            state     <= StDispatch;
            busy      <= 1'b1;
          end else if (!dir_up && (up_tgt != 4'd0)) begin
            dir_up    <= 1'b1;
            req_floor <= up_tgt;
            state     <= StDispatch;
            busy      <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        StDispatch: begin
          if (served) begin
            req_floor <= 4'd0;
            cnt       <= '0;
            state     <= StDwell;
          end else if (cnt == TimeoutLast) begin
            // Abandon the dispatch but keep the call so it is retried later.
            timeout_err <= 1'b1;
            req_floor   <= 4'd0;
            cnt         <= '0;
            state       <= StDwell;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDwell: begin
          if (alert) begin
            cnt <= '0;
          end else if (cnt == HoldLast) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.REQUESTED_FLOOR = req_floor;
  assign bus.PENDING         = pending;
  assign bus.BUSY            = busy;
  assign bus.TIMEOUT_ERR     = timeout_err;

endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Directed testbench for floor_request_dispatcher with HOLD_CYCLES=4, TIMEOUT_CYCLES=8.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_floor_request_dispatcher;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  floor_request_dispatcher_if bus ();

  floor_request_dispatcher #(
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [3:0] btn, input logic [3:0] floor, input logic comp);
    bus.CALL_BUTTONS  = btn;
    bus.CURRENT_FLOOR = floor;
    bus.COMPLETE      = comp;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.DOOR_ALERT   = 1'b0;
    bus.WEIGHT_ALERT = 1'b0;
    set_in(4'b0100, 4'b0001, 1'b0);

    // Reset state, button held through reset
    tick(2);
    check_value("rst_req", 32'(bus.REQUESTED_FLOOR), 32'h0);
    check_value("rst_pend", 32'(bus.PENDING), 32'h0);
    check_value("rst_busy", 32'(bus.BUSY), 32'h0);
    check_value("rst_tmo", 32'(bus.TIMEOUT_ERR), 32'h0);
    rst = 1'b1;
    tick(3);
    check_value("held_ignored", 32'(bus.PENDING), 32'h0);
    set_in(4'b0000, 4'b0001, 1'b0);
    tick(2);
    set_in(4'b0100, 4'b0001, 1'b0);
    tick(1);
    check_value("cap_lat1", 32'(bus.PENDING), 32'h0);
    tick(1);
    check_value("cap_pend", 32'(bus.PENDING), 32'h4);
    tick(1);
    check_value("sel_req0", 32'(bus.REQUESTED_FLOOR), 32'h0);
    tick(1);
    check_value("disp_req", 32'(bus.REQUESTED_FLOOR), 32'h4);
    check_value("disp_busy", 32'(bus.BUSY), 32'h1);
    set_in(4'b0000, 4'b0100, 1'b1);
    tick(1);
    set_in(4'b0000, 4'b0100, 1'b0);
    check_value("serve_pend", 32'(bus.PENDING), 32'h0);
    check_value("serve_req", 32'(bus.REQUESTED_FLOOR), 32'h0);
    check_value("dwell_busy", 32'(bus.BUSY), 32'h1);
    tick(3);
    check_value("dwell_busy3", 32'(bus.BUSY), 32'h1);
    tick(1);
    check_value("dwell_end", 32'(bus.BUSY), 32'h0);

    // SCAN ordering from floor 1, scanning up
    set_in(4'b1001, 4'b0010, 1'b0);
    tick(2);
    check_value("scan_pend", 32'(bus.PENDING), 32'h9);
    set_in(4'b0000, 4'b0010, 1'b0);
    tick(2);
    check_value("scan_up", 32'(bus.REQUESTED_FLOOR), 32'h8);
    set_in(4'b0000, 4'b0010, 1'b1);
    tick(1);
    check_value("wrong_floor_req", 32'(bus.REQUESTED_FLOOR), 32'h8);
    check_value("wrong_floor_pend", 32'(bus.PENDING), 32'h9);
    set_in(4'b1000, 4'b0010, 1'b0);
    tick(1);
    set_in(4'b1000, 4'b1000, 1'b1);
    tick(1);
    check_value("simul_pend", 32'(bus.PENDING), 32'h1);
    check_value("simul_req", 32'(bus.REQUESTED_FLOOR), 32'h0);
    set_in(4'b0000, 4'b1000, 1'b0);
    tick(5);
    check_value("flip_sel", 32'(bus.REQUESTED_FLOOR), 32'h0);
    tick(1);
    check_value("scan_down", 32'(bus.REQUESTED_FLOOR), 32'h1);
    set_in(4'b0000, 4'b0001, 1'b1);
    tick(1);
    set_in(4'b0000, 4'b0001, 1'b0);
    check_value("scan_done", 32'(bus.PENDING), 32'h0);
    tick(4);

    // Call at the current floor
    set_in(4'b0100, 4'b0100, 1'b0);
    tick(2);
    check_value("here_pend", 32'(bus.PENDING), 32'h4);
    tick(2);
    set_in(4'b0000, 4'b0100, 1'b0);
    check_value("here_clr", 32'(bus.PENDING), 32'h0);
    check_value("here_busy", 32'(bus.BUSY), 32'h1);
    check_value("here_req", 32'(bus.REQUESTED_FLOOR), 32'h0);
    tick(3);
    check_value("here_busy3", 32'(bus.BUSY), 32'h1);
    check_value("here_req3", 32'(bus.REQUESTED_FLOOR), 32'h0);
    tick(1);
    check_value("here_end", 32'(bus.BUSY), 32'h0);

    // Weight alert blocks selection; door alert restarts dwell
    bus.WEIGHT_ALERT = 1'b1;
    set_in(4'b1000, 4'b0001, 1'b0);
    tick(2);
    set_in(4'b0000, 4'b0001, 1'b0);
    check_value("wt_pend", 32'(bus.PENDING), 32'h8);
    tick(3);
    check_value("wt_busy", 32'(bus.BUSY), 32'h0);
    check_value("wt_req", 32'(bus.REQUESTED_FLOOR), 32'h0);
    bus.WEIGHT_ALERT = 1'b0;
    tick(2);
    check_value("wt_go", 32'(bus.REQUESTED_FLOOR), 32'h8);
    set_in(4'b0000, 4'b1000, 1'b1);
    tick(1);
    set_in(4'b0000, 4'b1000, 1'b0);
    tick(2);
    bus.DOOR_ALERT = 1'b1;
    tick(1);
    bus.DOOR_ALERT = 1'b0;
    tick(3);
    check_value("door_busy", 32'(bus.BUSY), 32'h1);
    tick(1);
    check_value("door_end", 32'(bus.BUSY), 32'h0);

    // Dispatch timeout and redispatch
    set_in(4'b1000, 4'b0001, 1'b0);
    tick(2);
    set_in(4'b0000, 4'b0001, 1'b0);
    tick(2);
    check_value("tmo_req", 32'(bus.REQUESTED_FLOOR), 32'h8);
    tick(7);
    check_value("tmo_pre", 32'(bus.TIMEOUT_ERR), 32'h0);
    check_value("tmo_hold", 32'(bus.REQUESTED_FLOOR), 32'h8);
    tick(1);
    check_value("tmo_err", 32'(bus.TIMEOUT_ERR), 32'h1);
    check_value("tmo_req0", 32'(bus.REQUESTED_FLOOR), 32'h0);
    check_value("tmo_pend", 32'(bus.PENDING), 32'h8);
    check_value("tmo_busy", 32'(bus.BUSY), 32'h1);
    tick(5);
    check_value("redisp_wait", 32'(bus.REQUESTED_FLOOR), 32'h0);
    tick(1);
    check_value("redisp", 32'(bus.REQUESTED_FLOOR), 32'h8);
    set_in(4'b0000, 4'b1000, 1'b1);
    tick(1);
    set_in(4'b0000, 4'b1000, 1'b0);
    check_value("redisp_pend", 32'(bus.PENDING), 32'h0);
    check_value("tmo_sticky", 32'(bus.TIMEOUT_ERR), 32'h1);
    tick(4);

    // Invalid position blocks selection, then asynchronous reset
    set_in(4'b0010, 4'b0110, 1'b0);
    tick(2);
    check_value("inv_pend", 32'(bus.PENDING), 32'h2);
    tick(3);
    check_value("inv_busy", 32'(bus.BUSY), 32'h0);
    check_value("inv_req", 32'(bus.REQUESTED_FLOOR), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check_value("arst_pend", 32'(bus.PENDING), 32'h0);
    check_value("arst_tmo", 32'(bus.TIMEOUT_ERR), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
